// File: rtl/remote_cmd_link_if.sv
// rtl/remote_cmd_link_if.sv - host-side command/response handshake bundle for remote_cmd_link.
interface remote_cmd_link_if;
   logic        send_cmd;
   logic [15:0] cmd;
   logic        clr_resp_rdy;
   logic        busy;
   logic        cmd_sent;
   logic        resp_rdy;
   logic [7:0]  resp;
   logic        resp_ok;
   logic        timeout;

   modport master (
      output send_cmd, cmd, clr_resp_rdy,
      input  busy, cmd_sent, resp_rdy, resp, resp_ok, timeout
   );

   modport slave (
      input  send_cmd, cmd, clr_resp_rdy,
      output busy, cmd_sent, resp_rdy, resp, resp_ok, timeout
   );
endinterface

// File: rtl/remote_cmd_link.sv
// rtl/remote_cmd_link.sv - two-byte UART command sender with one-byte response/timeout tracking.
module remote_cmd_link #(
   parameter int         BAUD_DIV    = 5208,
   parameter logic [7:0] ACK_BYTE    = 8'hA5,
   parameter int         TIMEOUT_CYC = 2500000
) (
   input  logic                clk,
   input  logic                rst,
   remote_cmd_link_if.slave    host,
   input  logic                RX,
   output logic                TX
);
   localparam int BW = $clog2(BAUD_DIV);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [BW-1:0] BAUD_LAST      = BW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] BAUD_HALF_LAST = BW'(BAUD_DIV / 2 - 1);
   localparam logic [TW-1:0] TO_LAST        = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO, WAIT_RESP} state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   state_t      state, state_next;
   logic [15:0] cmd_q;
   logic [BW-1:0] tx_cnt;
   logic [3:0]  tx_bit;
   logic        tx_q;
   logic [TW-1:0] to_cnt;
   logic        accept, tx_bit_end, tx_frame_end;
   logic        cmd_sent_next, timeout_next;
   logic        cmd_sent_q, timeout_q;
   logic [7:0]  cur_byte;

   rx_state_t   rx_state, rx_state_next;
   logic        rx_meta, rx_sync, rx_prev;
   logic [BW-1:0] rx_cnt;
   logic [2:0]  rx_bit;
   logic [7:0]  rx_shift;
   logic        rx_done;
   logic        resp_rdy_q;
   logic [7:0]  resp_q;

   // Frame bit idx: 0 = start, 1..8 = data LSB first, 9 = stop.
   function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
      if (idx == 4'd0)
         return 1'b0;
      else if (idx >= 4'd9)
         return 1'b1;
      else
         return b[3'(idx - 4'd1)];
   endfunction

   assign tx_bit_end   = (tx_cnt == BAUD_LAST);
   assign tx_frame_end = tx_bit_end && (tx_bit == 4'd9);
   assign cur_byte     = (state == SEND_HI) ? cmd_q[15:8] : cmd_q[7:0];
   assign rx_done      = (rx_state == RX_STOP) && (rx_cnt == BAUD_LAST) && rx_sync;

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next    = state;
      accept        = 1'b0;
      cmd_sent_next = 1'b0;
      timeout_next  = 1'b0;
      case (state)
         IDLE: begin
            if (host.send_cmd) begin
               accept     = 1'b1;
               state_next = SEND_HI;
            end
         end
         SEND_HI: begin
            if (tx_frame_end)
               state_next = SEND_LO;
         end
         SEND_LO: begin
            if (tx_frame_end) begin
               cmd_sent_next = 1'b1;
               state_next    = WAIT_RESP;
            end
         end
         WAIT_RESP: begin
            // A byte landing on the expiry cycle takes priority over the timeout.
            if (rx_done) begin
               state_next = IDLE;
            end else if (to_cnt == TO_LAST) begin
               timeout_next = 1'b1;
               state_next   = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_q       <= 1'b1;
         tx_cnt     <= '0;
         tx_bit     <= '0;
         cmd_q      <= '0;
         to_cnt     <= '0;
         cmd_sent_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         cmd_sent_q <= cmd_sent_next;
         timeout_q  <= timeout_next;
         if (accept) begin
            cmd_q  <= host.cmd;
            tx_q   <= 1'b0;
            tx_cnt <= '0;
            tx_bit <= '0;
         end else if (state == SEND_HI || state == SEND_LO) begin
            if (tx_bit_end) begin
               tx_cnt <= '0;
               if (tx_bit == 4'd9) begin
                  // High byte's stop flows straight into the low byte's start bit.
                  tx_bit <= '0;
                  tx_q   <= (state == SEND_HI) ? 1'b0 : 1'b1;
               end else begin
                  tx_bit <= tx_bit + 4'd1;
                  tx_q   <= frame_bit(cur_byte, tx_bit + 4'd1);
               end
            end else begin
               tx_cnt <= tx_cnt + BW'(1);
            end
         end else begin
            tx_q <= 1'b1;
         end
         if (state == WAIT_RESP)
            to_cnt <= to_cnt + TW'(1);
         else
            to_cnt <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         rx_state <= RX_IDLE;
      else
         rx_state <= rx_state_next;
   end

   always_comb begin
      rx_state_next = rx_state;
      case (rx_state)
         RX_IDLE:  if (!rx_sync && rx_prev) rx_state_next = RX_START;
         RX_START: if (rx_cnt == BAUD_HALF_LAST) rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_cnt == BAUD_LAST && rx_bit == 3'd7) rx_state_next = RX_STOP;
         RX_STOP:  if (rx_cnt == BAUD_LAST) rx_state_next = RX_IDLE;
         default:  rx_state_next = RX_IDLE;
      endcase
   end

   // rx_meta/rx_sync form the two-flop synchronizer; nothing else reads rx_meta.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta    <= 1'b1;
         rx_sync    <= 1'b1;
         rx_prev    <= 1'b1;
         rx_cnt     <= '0;
         rx_bit     <= '0;
         rx_shift   <= '0;
         resp_q     <= '0;
         resp_rdy_q <= 1'b0;
      end else begin
         rx_meta <= RX;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
         case (rx_state)
            RX_IDLE: begin
               rx_cnt <= '0;
               rx_bit <= '0;
            end
            RX_START: begin
               if (rx_cnt == BAUD_HALF_LAST)
                  rx_cnt <= '0;
               else
                  rx_cnt <= rx_cnt + BW'(1);
            end
            RX_DATA: begin
               if (rx_cnt == BAUD_LAST) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rx_sync, rx_shift[7:1]};
                  rx_bit   <= rx_bit + 3'd1;
               end else begin
                  rx_cnt <= rx_cnt + BW'(1);
               end
            end
            RX_STOP: begin
               if (rx_cnt == BAUD_LAST)
                  rx_cnt <= '0;
               else
                  rx_cnt <= rx_cnt + BW'(1);
            end
            default: rx_cnt <= '0;
         endcase
         if (rx_done)
            resp_q <= rx_shift;
         if (rx_done)
            resp_rdy_q <= 1'b1;
         else if (host.clr_resp_rdy || accept)
            resp_rdy_q <= 1'b0;
      end
   end

   assign TX            = tx_q;
   assign host.busy     = (state != IDLE);
   assign host.cmd_sent = cmd_sent_q;
   assign host.timeout  = timeout_q;
   assign host.resp     = resp_q;
   assign host.resp_rdy = resp_rdy_q;
   assign host.resp_ok  = resp_rdy_q && (resp_q == ACK_BYTE);
endmodule

// File: tb/tb_remote_cmd_link.sv
// tb/tb_remote_cmd_link.sv - directed and randomized bench for remote_cmd_link with a bit-level UART model.
module tb_remote_cmd_link;
   localparam int BAUD = 16;
   localparam int TOUT = 2000;
   localparam logic [7:0] ACK = 8'hA5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx  = 1'b1;
   logic tx;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [7:0] exp_resp = 8'h00;

   remote_cmd_link_if host_if();

   remote_cmd_link #(.BAUD_DIV(BAUD), .ACK_BYTE(ACK), .TIMEOUT_CYC(TOUT)) dut (
      .clk  (clk),
      .rst  (rst),
      .host (host_if),
      .RX   (rx),
      .TX   (tx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Line level n cycles after TX leaves idle for a two-byte 8N1 command.
   function automatic logic exp_tx(input logic [15:0] c, input int n);
      int byte_i = n / (10 * BAUD);
      int bit_i  = (n % (10 * BAUD)) / BAUD;
      logic [7:0] b = (byte_i == 0) ? c[15:8] : c[7:0];
      if (byte_i > 1)  return 1'b1;
      if (bit_i == 0)  return 1'b0;
      if (bit_i == 9)  return 1'b1;
      return b[bit_i - 1];
   endfunction

   task automatic send_frame(input logic [15:0] c, input bit poke_lo);
      int bad_tx = 0, bad_busy = 0, bad_sent = 0;
      @(negedge clk);
      host_if.send_cmd = 1'b1;
      host_if.cmd      = c;
      @(negedge clk);
      host_if.send_cmd = 1'b0;
      host_if.cmd      = 16'($urandom);
      check("resp_rdy_cleared_on_send", host_if.resp_rdy, 0);
      for (int n = 0; n < 20 * BAUD; n++) begin
         if (tx !== exp_tx(c, n)) bad_tx++;
         if (host_if.busy !== 1'b1) bad_busy++;
         if (host_if.cmd_sent !== 1'b0) bad_sent++;
         if (poke_lo && n == 13 * BAUD) begin
            host_if.send_cmd = 1'b1;
            host_if.cmd      = ~c;
         end else begin
            host_if.send_cmd = 1'b0;
         end
         @(negedge clk);
      end
      check("tx_bitstream_errors", bad_tx, 0);
      check("busy_low_during_send", bad_busy, 0);
      check("cmd_sent_early", bad_sent, 0);
      check("cmd_sent_at_20_bits", host_if.cmd_sent, 1);
      check("tx_idle_after_frame", tx, 1);
   endtask

   task automatic rx_byte(input logic [7:0] b, input logic stop);
      logic [9:0] frame = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = frame[i];
         repeat (BAUD) @(negedge clk);
      end
      rx = 1'b1;
   endtask

   task automatic resp_cycle(input logic [15:0] c, input logic [7:0] b, input bit poke_lo);
      send_frame(c, poke_lo);
      rx_byte(b, 1'b1);
      repeat (2) @(negedge clk);
      exp_resp = b;
      check("resp_value", host_if.resp, exp_resp);
      check("resp_rdy_set", host_if.resp_rdy, 1);
      check("resp_ok", host_if.resp_ok, (b == ACK));
      check("busy_idle_after_resp", host_if.busy, 0);
   endtask

   initial begin
      logic [15:0] c;
      logic [7:0]  b;
      int          j;
      bit          seen;

      host_if.send_cmd     = 1'b0;
      host_if.cmd          = 16'h0000;
      host_if.clr_resp_rdy = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_tx", tx, 1);
      check("reset_busy", host_if.busy, 0);
      check("reset_cmd_sent", host_if.cmd_sent, 0);
      check("reset_resp_rdy", host_if.resp_rdy, 0);
      check("reset_timeout", host_if.timeout, 0);
      check("reset_resp", host_if.resp, 0);
      check("reset_resp_ok", host_if.resp_ok, 0);
      rst = 1'b0;

      send_frame(16'h3C81, 1'b0);
      @(negedge clk);
      check("cmd_sent_single_pulse", host_if.cmd_sent, 0);
      rx_byte(8'hA5, 1'b1);
      repeat (2) @(negedge clk);
      exp_resp = 8'hA5;
      check("ack_resp", host_if.resp, exp_resp);
      check("ack_resp_rdy", host_if.resp_rdy, 1);
      check("ack_resp_ok", host_if.resp_ok, 1);
      check("ack_busy", host_if.busy, 0);

      resp_cycle(16'h1234, 8'h5A, 1'b0);

      for (int i = 0; i < 5; i++) begin
         c = 16'($urandom);
         b = ($urandom_range(0, 2) == 0) ? ACK : 8'($urandom);
         resp_cycle(c, b, 1'b0);
      end

      send_frame(16'($urandom), 1'b0);
      j = 0;
      seen = 1'b0;
      while (j < TOUT + 500 && !seen) begin
         @(negedge clk);
         j++;
         if (j == 1) check("cmd_sent_pulse_width", host_if.cmd_sent, 0);
         if (host_if.timeout === 1'b1) seen = 1'b1;
      end
      check("timeout_latency", j, TOUT);
      check("timeout_busy_low", host_if.busy, 0);
      check("timeout_resp_rdy", host_if.resp_rdy, 0);
      @(negedge clk);
      check("timeout_pulse_width", host_if.timeout, 0);

      host_if.clr_resp_rdy = 1'b1;
      @(negedge clk);
      host_if.clr_resp_rdy = 1'b0;
      check("clr_resp_rdy", host_if.resp_rdy, 0);
      rx_byte(8'($urandom), 1'b0);
      repeat (4) @(negedge clk);
      check("framing_err_rdy", host_if.resp_rdy, 0);
      check("framing_err_resp_kept", host_if.resp, exp_resp);
      rx = 1'b0;
      repeat (BAUD / 2) @(negedge clk);
      rx = 1'b1;
      repeat (3 * BAUD) @(negedge clk);
      check("glitch_rdy", host_if.resp_rdy, 0);
      check("glitch_resp_kept", host_if.resp, exp_resp);
      rx_byte(8'h33, 1'b1);
      repeat (2) @(negedge clk);
      exp_resp = 8'h33;
      check("after_glitch_resp", host_if.resp, exp_resp);
      check("after_glitch_rdy", host_if.resp_rdy, 1);
      check("after_glitch_ok", host_if.resp_ok, 0);

      resp_cycle(16'hC3E7, ACK, 1'b1);

      c = 16'($urandom);
      @(negedge clk);
      host_if.send_cmd = 1'b1;
      host_if.cmd      = c;
      @(negedge clk);
      host_if.send_cmd = 1'b0;
      repeat (3 * BAUD) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midframe_reset_tx", tx, 1);
      check("midframe_reset_busy", host_if.busy, 0);
      @(negedge clk);
      check("post_reset_tx_idle", tx, 1);
      resp_cycle(16'($urandom), 8'($urandom), 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
